// File: rtl/input_pkg.sv
// input_pkg: shared button count, debounce default and per-bit FSM state type
package input_pkg;
  localparam int NUM_BTNS = 5;
  localparam int DB_CYCLES_DEF = 50000;
  typedef enum logic [1:0] {STABLE_LOW, WAIT_HIGH, STABLE_HIGH, WAIT_LOW} db_state_t;
endpackage

// File: rtl/debounce_bit.sv
// debounce_bit: one-button synchronizer, debounce FSM/counter and rising press pulse
//   clk    : rising-edge clock
//   reset  : async active-low reset
//   raw    : unsynchronized button pin
//   stable : debounced level
//   press  : one-cycle pulse after stable rises
module debounce_bit
  import input_pkg::*;
#(
  parameter int DB_CYCLES = DB_CYCLES_DEF,
  parameter int CNT_W = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic stable,
  output logic press
);
  logic s1, s2;
  logic [CNT_W-1:0] cnt;
  db_state_t st;
  wire last = cnt == CNT_W'(DB_CYCLES - 1);
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      st <= STABLE_LOW;
      cnt <= '0;
      stable <= 1'b0;
      press <= 1'b0;
    end else begin
      s1 <= raw;
      s2 <= s1;
      press <= 1'b0;
      case (st)
        STABLE_LOW: begin
          st <= s2 ? WAIT_HIGH : STABLE_LOW;
          cnt <= s2 ? CNT_W'(1) : '0;
        end
        STABLE_HIGH: begin
          st <= s2 ? STABLE_HIGH : WAIT_LOW;
          cnt <= s2 ? '0 : CNT_W'(1);
        end
        WAIT_HIGH:
          if (!s2) begin
            st <= STABLE_LOW;
            cnt <= '0;
          end else if (last) begin
            st <= STABLE_HIGH;
            cnt <= '0;
            stable <= 1'b1;
            press <= 1'b1;
          end else cnt <= cnt + CNT_W'(1);
        WAIT_LOW:
          if (s2) begin
            st <= STABLE_HIGH;
            cnt <= '0;
          end else if (last) begin
            st <= STABLE_LOW;
            cnt <= '0;
            stable <= 1'b0;
          end else cnt <= cnt + CNT_W'(1);
        default: begin
          st <= STABLE_LOW;
          cnt <= '0;
        end
      endcase
    end
  end
endmodule

// File: rtl/input_debounce.sv
// input_debounce: debounces NUM_BTNS controller buttons with press pulses and optional sticky flags
//   clk        : rising-edge clock
//   reset      : async active-low reset
//   btn_raw    : raw button pins
//   clear      : acknowledge strobe, clears sticky flags
//   btn_stable : debounced levels
//   btn_press  : one-cycle press pulses
//   btn_sticky : latched presses (only built with INPUT_DEBOUNCE_STICKY_EN, else 0)
module input_debounce
  import input_pkg::*;
#(
  parameter int DB_CYCLES = DB_CYCLES_DEF,
  parameter int CNT_W = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_BTNS-1:0] btn_raw,
  input  logic                clear,
  output logic [NUM_BTNS-1:0] btn_stable,
  output logic [NUM_BTNS-1:0] btn_press,
  output logic [NUM_BTNS-1:0] btn_sticky
);
  for (genvar i = 0; i < NUM_BTNS; i++) begin : g_bit
    debounce_bit #(.DB_CYCLES(DB_CYCLES), .CNT_W(CNT_W)) u_bit (
      .clk(clk),
      .reset(reset),
      .raw(btn_raw[i]),
      .stable(btn_stable[i]),
      .press(btn_press[i])
    );
  end
`ifdef INPUT_DEBOUNCE_STICKY_EN
  // a press arriving with clear wins so no press is lost
  always_ff @(posedge clk or negedge reset)
    if (!reset) btn_sticky <= '0;
    else btn_sticky <= (btn_sticky & ~{NUM_BTNS{clear}}) | btn_press;
`else
  logic unused_clear;
  assign unused_clear = clear;
  assign btn_sticky = '0;
`endif
endmodule

// File: tb/tb_input_debounce.sv
// tb_input_debounce: randomized and directed checks of input_debounce against a run-length model
module tb_input_debounce;
  localparam int DB = 4;
  logic clk = 1'b0, reset = 1'b0, clear = 1'b0;
  logic [4:0] btn_raw = '0;
  logic [4:0] btn_stable, btn_press, btn_sticky;
  int checks = 0, errors = 0;
  logic [4:0] m_q[$];
  logic [4:0] m_stable = '0, m_press = '0, m_sticky = '0;
  int m_run[5];

  input_debounce #(.DB_CYCLES(DB), .CNT_W(3)) dut (
    .clk(clk), .reset(reset), .btn_raw(btn_raw), .clear(clear),
    .btn_stable(btn_stable), .btn_press(btn_press), .btn_sticky(btn_sticky)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  task automatic model_reset();
    m_q.delete();
    m_stable = '0;
    m_press = '0;
    m_sticky = '0;
    for (int i = 0; i < 5; i++) m_run[i] = 0;
  endtask

  // A level is accepted once DB consecutive synchronized samples differ from
  // the current debounced level; a synchronized sample is the raw value two edges back.
  task automatic model_edge();
    logic [4:0] seen, old_press;
    seen = (m_q.size() >= 2) ? m_q[m_q.size()-2] : 5'b0;
    m_q.push_back(btn_raw);
    if (m_q.size() > 4) void'(m_q.pop_front());
    old_press = m_press;
    m_press = '0;
    for (int i = 0; i < 5; i++) begin
      if (seen[i] != m_stable[i]) begin
        m_run[i]++;
        if (m_run[i] == DB) begin
          m_stable[i] = seen[i];
          m_press[i] = seen[i];
          m_run[i] = 0;
        end
      end else m_run[i] = 0;
    end
`ifdef INPUT_DEBOUNCE_STICKY_EN
    m_sticky = (m_sticky & ~{5{clear}}) | old_press;
`else
    m_sticky = old_press & 5'b0;
`endif
  endtask

  task automatic step();
    @(posedge clk);
    if (reset) model_edge(); else model_reset();
    @(negedge clk);
  endtask

  task automatic test_reset();
    btn_raw = 5'b11111;
    clear = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({btn_stable, btn_press, btn_sticky} !== 15'b0) begin
      errors++;
      $display("FAIL reset_hold got %b/%b/%b exp 0", btn_stable, btn_press, btn_sticky);
    end
    btn_raw = '0;
    clear = 1'b0;
    reset = 1'b1;
    model_reset();
  endtask

  // 10101 held: stable on the sixth edge counting the first sampling edge
  task automatic test_pattern();
    btn_raw = 5'b10101;
    for (int e = 1; e <= 7; e++) begin
      step();
      checks++;
      if (btn_stable !== (e >= 6 ? 5'b10101 : 5'b0)) begin
        errors++;
        $display("FAIL pattern_stable edge %0d got %b exp %b", e, btn_stable, e >= 6 ? 5'b10101 : 5'b0);
      end
      checks++;
      if (btn_press !== (e == 6 ? 5'b10101 : 5'b0)) begin
        errors++;
        $display("FAIL pattern_press edge %0d got %b exp %b", e, btn_press, e == 6 ? 5'b10101 : 5'b0);
      end
    end
  endtask

  task automatic test_release();
    btn_raw = '0;
    for (int e = 1; e <= 7; e++) begin
      step();
      checks++;
      if (btn_stable !== (e >= 6 ? 5'b0 : 5'b10101) || btn_press !== 5'b0) begin
        errors++;
        $display("FAIL release edge %0d got %b/%b exp %b/00000", e, btn_stable, btn_press, e >= 6 ? 5'b0 : 5'b10101);
      end
    end
  endtask

  task automatic test_glitch();
    btn_raw = 5'b00001;
    repeat (3) step();
    btn_raw = '0;
    for (int e = 0; e < 8; e++) begin
      step();
      checks++;
      if ({btn_stable, btn_press, btn_sticky} !== 15'b0) begin
        errors++;
        $display("FAIL glitch got %b/%b/%b exp 0", btn_stable, btn_press, btn_sticky);
      end
    end
  endtask

  task automatic test_sticky();
    logic [4:0] exp_set;
`ifdef INPUT_DEBOUNCE_STICKY_EN
    exp_set = 5'b00100;
`else
    exp_set = 5'b00000;
`endif
    btn_raw = 5'b00100;
    repeat (6) step();
    checks++;
    if (btn_press !== 5'b00100) begin
      errors++;
      $display("FAIL sticky_press got %b exp 00100", btn_press);
    end
    clear = 1'b1;
    step();
    checks++;
    if (btn_sticky !== exp_set || btn_sticky !== m_sticky) begin
      errors++;
      $display("FAIL sticky_setwins got %b exp %b", btn_sticky, exp_set);
    end
    step();
    checks++;
    if (btn_sticky !== 5'b0) begin
      errors++;
      $display("FAIL sticky_clear got %b exp 00000", btn_sticky);
    end
    clear = 1'b0;
    btn_raw = '0;
    repeat (8) step();
  endtask

  task automatic test_reset_mid();
    btn_raw = 5'b00011;
    repeat (8) step();
    btn_raw = 5'b11100;
    repeat (3) step();
    #2 reset = 1'b0;
    #1;
    checks++;
    if ({btn_stable, btn_press, btn_sticky} !== 15'b0) begin
      errors++;
      $display("FAIL midreset_async got %b/%b/%b exp 0", btn_stable, btn_press, btn_sticky);
    end
    @(negedge clk);
    reset = 1'b1;
    model_reset();
    for (int e = 1; e <= 6; e++) begin
      step();
      checks++;
      if (btn_stable !== (e == 6 ? 5'b11100 : 5'b0) || btn_stable !== m_stable) begin
        errors++;
        $display("FAIL midreset_requal edge %0d got %b exp %b", e, btn_stable, e == 6 ? 5'b11100 : 5'b0);
      end
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < 5; i++)
        if ($urandom_range(0, 9) < 2) btn_raw[i] = ~btn_raw[i];
      clear = ($urandom_range(0, 7) == 0);
      step();
      checks++;
      if (btn_stable !== m_stable || btn_press !== m_press || btn_sticky !== m_sticky) begin
        errors++;
        $display("FAIL random cycle %0d got %b/%b/%b exp %b/%b/%b", c, btn_stable, btn_press, btn_sticky, m_stable, m_press, m_sticky);
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_pattern();
    test_release();
    test_glitch();
    test_sticky();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
